if_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue, replacing the single-entry fetch/IF_ID hand-off of the pipelined ARMv8 core. It issues sequential PC fetches to instruction memory, tolerates variable memory latency, and buffers {PC, instruction} pairs for the decode stage. It also supports decode back-pressure and a branch/BR redirect that flushes all queued and in-flight fetches.

---
 rtl/if_prefetch_queue.sv | 126 ++++++++++++
 tb/tb_if_prefetch_queue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: sequential PC fetch with one outstanding request and a DEPTH-entry {PC, instr} queue.
// Optional combinational response bypass on an empty queue when IF_PREFETCH_BYPASS_EN is defined.
module if_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              INSTR_W  = 32,
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic                         imem_valid,
  input  logic [INSTR_W-1:0]           imem_data,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         deq_ready,
  output logic                         deq_valid,
  output logic [INSTR_W-1:0]           deq_instr,
  output logic [PC_W-1:0]              deq_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DROP} state_t;

  state_t               state_reg, state_next;
  logic [PC_W-1:0]      fetch_pc_reg, fetch_pc_next;
  logic [AW-1:0]        rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic [INSTR_W-1:0]   instr_mem [DEPTH];
  logic [PC_W-1:0]      pc_mem [DEPTH];

  logic resp_ok, bypass_hit, push, pop, not_full;

  assign not_full = (count_reg < CW'(DEPTH));
  assign resp_ok  = (state_reg == S_WAIT) && imem_valid && !redirect && !reset;

`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass_hit = resp_ok && (count_reg == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign deq_valid = !reset && !redirect && ((count_reg != '0) || bypass_hit);
  assign pop       = deq_valid && deq_ready && (count_reg != '0);
  // A bypassed response that decode takes immediately never occupies a slot.
  assign push      = resp_ok && !(bypass_hit && deq_ready);

  assign deq_instr = bypass_hit ? imem_data    : instr_mem[rd_ptr_reg];
  assign deq_pc    = bypass_hit ? fetch_pc_reg : pc_mem[rd_ptr_reg];
  assign imem_addr = reset ? '0 : fetch_pc_reg;
  assign count     = count_reg;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    imem_req      = 1'b0;
    if (redirect) begin
      fetch_pc_next = redirect_pc;
      // A request still in flight must be drained before the new stream starts.
      if ((state_reg != S_ISSUE) && !imem_valid) state_next = S_DROP;
      else                                       state_next = S_ISSUE;
    end else begin
      case (state_reg)
        S_ISSUE: begin
          if (not_full && !reset) begin
            imem_req   = 1'b1;
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            fetch_pc_next = fetch_pc_reg + PC_W'(4);
            state_next    = S_ISSUE;
          end
        end
        S_DROP: begin
          if (imem_valid) state_next = S_ISSUE;
        end
        default: state_next = S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= S_ISSUE;
      fetch_pc_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || redirect) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (reset) begin
        instr_mem[gi] <= '0;
        pc_mem[gi]    <= '0;
      end else if (push && (wr_ptr_reg == AW'(gi))) begin
        instr_mem[gi] <= imem_data;
        pc_mem[gi]    <= fetch_pc_reg;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a latency-programmable in-order memory model.
module tb_if_prefetch_queue;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [63:0] deq_pc;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  int          lat = 1;
  int          cnt = 0;
  bit          pending = 0;
  bit          inject_late = 0;
  logic [63:0] pend_addr;

  logic [63:0] req_q[$];
  logic [63:0] dpc_q[$];
  logic [31:0] din_q[$];

  if_prefetch_queue #(
    .DEPTH(4), .INSTR_W(32), .PC_W(64), .RESET_PC(64'h100)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Memory: a request seen in cycle t is answered in cycle t+lat with data E0000000+addr.
  initial begin
    imem_valid = 0;
    imem_data  = 0;
    pend_addr  = 0;
    forever begin
      @(negedge clock);
      imem_valid = 0;
      if (reset) begin
        pending = 0;
        if (inject_late) begin
          imem_valid = 1;
          imem_data  = 32'hDEADBEEF;
        end
      end else begin
        if (pending) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            imem_valid = 1;
            imem_data  = pend_addr[31:0] + 32'hE000_0000;
            pending    = 0;
          end
        end
        if (imem_req === 1'b1) begin
          pending   = 1;
          cnt       = lat;
          pend_addr = imem_addr;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    redirect = 0;
    settle();
    tick();
    reset = 0;
  endtask

  task automatic run_record(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      if (imem_req === 1'b1) req_q.push_back(imem_addr);
      if (deq_valid === 1'b1 && deq_ready === 1'b1) begin
        dpc_q.push_back(deq_pc);
        din_q.push_back(deq_instr);
        $display("deq pc=%h instr=%h count=%0d", deq_pc, deq_instr, count);
      end
      tick();
    end
  endtask

  task automatic clear_q();
    req_q = {};
    dpc_q = {};
    din_q = {};
  endtask

  task automatic test_reset();
    deq_ready = 1;
    reset = 1;
    redirect = 0;
    settle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL rst_deq_valid: got %b want 0", deq_valid); end
    tick();
    reset = 0;
    settle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_after: got %b want 0", deq_valid); end
    total++; if (deq_pc !== 64'h0) begin bad++; $display("FAIL rst_deq_pc: got %h want 0", deq_pc); end
    total++; if (deq_instr !== 32'h0) begin bad++; $display("FAIL rst_deq_instr: got %h want 0", deq_instr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", imem_req); end
    total++; if (imem_addr !== 64'h100) begin bad++; $display("FAIL first_addr: got %h want 100", imem_addr); end
    $display("reset: req=%b addr=%h count=%0d", imem_req, imem_addr, count);
    tick();
  endtask

  task automatic test_sequential();
    lat = 1;
    deq_ready = 1;
    do_reset();
    clear_q();
    run_record(14);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] exp_pc;
      exp_pc = 64'h100 + 64'(4 * i);
      total++; if (req_q[i] !== exp_pc) begin bad++; $display("FAIL seq_addr%0d: got %h want %h", i, req_q[i], exp_pc); end
      total++; if (dpc_q[i] !== exp_pc) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", i, dpc_q[i], exp_pc); end
      total++; if (din_q[i] !== exp_pc[31:0] + 32'hE000_0000) begin bad++; $display("FAIL seq_instr%0d: got %h want %h", i, din_q[i], exp_pc[31:0] + 32'hE000_0000); end
    end
  endtask

  task automatic test_backpressure();
    lat = 1;
    deq_ready = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      settle();
      if (count === 3'd4) break;
      tick();
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_full: got %0d want 4", count); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req: got %b want 0", imem_req); end
    total++; if (deq_pc !== 64'h100) begin bad++; $display("FAIL bp_head: got %h want 100", deq_pc); end
    $display("backpressure: count=%0d req=%b head=%h", count, imem_req, deq_pc);
    tick();
    deq_ready = 1;
    clear_q();
    run_record(12);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] exp_pc;
      exp_pc = 64'h100 + 64'(4 * i);
      total++; if (dpc_q[i] !== exp_pc) begin bad++; $display("FAIL bp_pop%0d: got %h want %h", i, dpc_q[i], exp_pc); end
    end
    total++; if (din_q[3] !== 32'hE000_010C) begin bad++; $display("FAIL bp_instr3: got %h want e000010c", din_q[3]); end
    total++; if (req_q[0] !== 64'h110) begin bad++; $display("FAIL bp_resume: got %h want 110", req_q[0]); end
  endtask

  task automatic test_redirect_wait();
    lat = 3;
    deq_ready = 1;
    do_reset();
    settle();
    tick();
    redirect = 1;
    redirect_pc = 64'h2000;
    settle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdw_req: got %b want 0", imem_req); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL rdw_valid: got %b want 0", deq_valid); end
    tick();
    redirect = 0;
    settle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rdw_count: got %0d want 0", count); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdw_drop_req: got %b want 0", imem_req); end
    tick();
    clear_q();
    run_record(20);
    total++; if (req_q[0] !== 64'h2000) begin bad++; $display("FAIL rdw_new_addr: got %h want 2000", req_q[0]); end
    total++; if (dpc_q[0] !== 64'h2000) begin bad++; $display("FAIL rdw_new_pc: got %h want 2000", dpc_q[0]); end
    total++; if (din_q[0] !== 32'hE000_2000) begin bad++; $display("FAIL rdw_new_instr: got %h want e0002000", din_q[0]); end
  endtask

  task automatic test_redirect_coincident();
    lat = 1;
    deq_ready = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      settle();
      tick();
    end
    settle();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL rdc_pre_count: got %0d want 2", count); end
    tick();
    redirect = 1;
    redirect_pc = 64'h3000;
    deq_ready = 1;
    settle();
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL rdc_valid: got %b want 0", deq_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdc_req: got %b want 0", imem_req); end
    tick();
    redirect = 0;
    settle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rdc_count: got %0d want 0", count); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL rdc_valid_after: got %b want 0", deq_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rdc_req_after: got %b want 1", imem_req); end
    total++; if (imem_addr !== 64'h3000) begin bad++; $display("FAIL rdc_addr: got %h want 3000", imem_addr); end
    $display("redirect coincident: count=%0d addr=%h", count, imem_addr);
    tick();
  endtask

  task automatic test_reset_midstream();
    lat = 3;
    deq_ready = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      settle();
      tick();
    end
    settle();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL rms_pre_count: got %0d want 3", count); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rms_pre_req: got %b want 1", imem_req); end
    tick();
    reset = 1;
    inject_late = 1;
    settle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rms_req_in_reset: got %b want 0", imem_req); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL rms_valid_in_reset: got %b want 0", deq_valid); end
    tick();
    reset = 0;
    inject_late = 0;
    settle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rms_count: got %0d want 0", count); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL rms_valid: got %b want 0", deq_valid); end
    total++; if (imem_addr !== 64'h100) begin bad++; $display("FAIL rms_addr: got %h want 100", imem_addr); end
    tick();
    deq_ready = 1;
    clear_q();
    run_record(15);
    total++; if (dpc_q[0] !== 64'h100) begin bad++; $display("FAIL rms_first_pc: got %h want 100", dpc_q[0]); end
    total++; if (din_q[0] !== 32'hE000_0100) begin bad++; $display("FAIL rms_first_instr: got %h want e0000100", din_q[0]); end
  endtask

  task automatic test_bypass();
    lat = 1;
    deq_ready = 1;
    do_reset();
    settle();
    tick();
    settle();
`ifdef IF_PREFETCH_BYPASS_EN
    total++; if (deq_valid !== 1'b1) begin bad++; $display("FAIL byp_valid: got %b want 1", deq_valid); end
    total++; if (deq_pc !== 64'h100) begin bad++; $display("FAIL byp_pc: got %h want 100", deq_pc); end
    total++; if (deq_instr !== 32'hE000_0100) begin bad++; $display("FAIL byp_instr: got %h want e0000100", deq_instr); end
`else
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL nobyp_valid: got %b want 0", deq_valid); end
`endif
    total++; if (count !== 3'd0) begin bad++; $display("FAIL byp_count_resp: got %0d want 0", count); end
    tick();
    settle();
`ifdef IF_PREFETCH_BYPASS_EN
    total++; if (count !== 3'd0) begin bad++; $display("FAIL byp_count_next: got %0d want 0", count); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL byp_valid_next: got %b want 0", deq_valid); end
`else
    total++; if (deq_valid !== 1'b1) begin bad++; $display("FAIL nobyp_valid_next: got %b want 1", deq_valid); end
    total++; if (deq_pc !== 64'h100) begin bad++; $display("FAIL nobyp_pc: got %h want 100", deq_pc); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL nobyp_count: got %0d want 1", count); end
`endif
    $display("bypass: valid=%b pc=%h count=%0d", deq_valid, deq_pc, count);
    tick();
  endtask

  initial begin
    reset = 1;
    redirect = 0;
    redirect_pc = 0;
    deq_ready = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_reset_midstream();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
